adc_conv_sequencer: RTL and testbench
=====================================

// Module: adc_conv_sequencer
// PURPOSE
//   Parametrised ADC conversion sequencer. It drives the converter START pulse with a
//   programmable width, then tracks the converter's EOC handshake (high = converting,
//   falling edge = result ready). It rotates a channel select over NUM_CH inputs and
//   supports single-shot and continuous modes, with an EOC timeout guard.
//   Sits between the sampling-control logic and the external ADC/analog mux pins.
// PARAMETERS
//   START_WIDTH  2     clk cycles START is held high per conversion (>=1)
//   NUM_CH       4     channels in rotation (>=1); CH_W = max(1,$clog2(NUM_CH))
//   GAP          0     idle clk cycles between done and next START in continuous mode
//   TIMEOUT      1023  max clk cycles allowed in each EOC wait state before abort
//   SYNC_STAGES  2     synchroniser flops on async eoc input (>=2)
// PORTS
//   clk          in   1     system clock, all logic on posedge
//   reset        in   1     asynchronous, active-high reset
//   enable       in   1     sequencer enable; low = finish current conversion, then idle
//   continuous   in   1     1 = free-running conversions, 0 = one conversion per trigger
//   trigger      in   1     single-shot request, sampled in IDLE only
//   eoc          in   1     async from ADC; high while converting, falls at end of conversion
//   start        out  1     ADC start pulse, START_WIDTH cycles wide
//   ch_sel       out  CH_W  analog mux channel; stable from START entry to done
//   busy         out  1     high in every state except IDLE
//   done         out  1     one-cycle pulse: conversion on done_ch completed
//   done_ch      out  CH_W  channel of last completed conversion, held until next done
//   timeout_err  out  1     one-cycle pulse: EOC wait exceeded TIMEOUT
// BEHAVIOUR
//   Reset (async): state=IDLE, start=0, ch_sel=0, busy=0, done=0, done_ch=0,
//     timeout_err=0, sync chain=0, counters=0. Reset mid-conversion aborts; START drops at once.
//   eoc passes SYNC_STAGES flops; one further flop gives eoc_d for edge detection.
//   FSM states: IDLE, START, WAIT_HI, WAIT_LO, GAP.
//   IDLE: if enable & (continuous | trigger) -> START next cycle. trigger with enable=0 is dropped.
//   START: start=1 for exactly START_WIDTH cycles, then -> WAIT_HI.
//   WAIT_HI: synced eoc==1 -> WAIT_LO. Wait cycles > TIMEOUT -> timeout_err pulse, abort.
//   WAIT_LO: synced falling edge -> done=1 for one cycle, done_ch<=ch_sel, and
//     ch_sel<=(ch_sel==NUM_CH-1)?0:ch_sel+1 (wrap). Timeout rule as in WAIT_HI.
//     NUM_CH=1: ch_sel stays 0.
//   After done: if enable & continuous -> GAP (GAP=0 -> straight to START); else -> IDLE.
//   GAP: counts GAP cycles, then -> START; if enable falls during GAP -> IDLE.
//   Abort on timeout: ch_sel not advanced; continuous & enable -> GAP then retry the
//     same channel; otherwise -> IDLE.
//   Latency: eoc pin fall -> done high SYNC_STAGES+1 cycles later (+ <=1 cycle sampling).
//   trigger while busy is ignored (not queued). enable falling mid-conversion does not
//     abort; the sequence completes, then goes to IDLE.
//   The timeout counter is $clog2(TIMEOUT+1) bits, saturating, cleared on every state entry.
//   done and timeout_err are never asserted in the same cycle.
//   All outputs are registered; no combinational path from any input to any output.
// TESTING
//   1) Single shot, defaults: trigger 1 cycle, ADC model raises eoc 3 cycles after START
//      and drops it 10 cycles later -> START 2 cycles wide; done on ch 0; ch_sel=1; IDLE.
//   2) Continuous, NUM_CH=4, GAP=3: 6 conversions -> done_ch 0,1,2,3,0,1 (wrap);
//      exactly 3 idle cycles between each done and the next START rise.
//   3) Timeout, TIMEOUT=15: eoc held low -> timeout_err pulses 16 cycles after WAIT_HI
//      entry; ch_sel unchanged; continuous retries the same channel, single-shot idles.
//   4) Async reset asserted mid-START and mid-WAIT_LO -> all outputs 0 immediately; the
//      sequencer restarts cleanly on channel 0.
//   5) trigger pulsed during busy, and enable dropped during WAIT_LO -> no extra conversion;
//      the current conversion finishes with done, then IDLE with busy=0.
//   6) Latency check, SYNC_STAGES=3: eoc fall aligned to the clock edge -> done 4 cycles later.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: drives the ADC START pulse, follows the EOC handshake
// through a synchroniser, rotates the analog mux channel and guards each EOC
// wait with a saturating timeout. All outputs come straight from flops.
module adc_conv_sequencer #(
  parameter int START_WIDTH = 2,
  parameter int NUM_CH      = 4,
  parameter int GAP         = 0,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            continuous,
  input  logic            trigger,
  input  logic            eoc,
  output logic            start,
  output logic [CH_W-1:0] ch_sel,
  output logic            busy,
  output logic            done,
  output logic [CH_W-1:0] done_ch,
  output logic            timeout_err
);

  // Timeout counter is just wide enough to reach TIMEOUT.
  localparam int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Shared START/GAP cycle counter, counts 0 .. max(START_WIDTH,GAP)-1.
  localparam int SEQ_MAX = (START_WIDTH > GAP) ? START_WIDTH : GAP;
  localparam int SC_W    = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT);
  localparam logic [SC_W-1:0] SW_LAST  = SC_W'(START_WIDTH - 1);
  localparam logic [SC_W-1:0] GAP_LAST = (GAP > 0) ? SC_W'(GAP - 1) : {SC_W{1'b0}};
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  state_t                 resume_s;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   eoc_s;
  logic                   eoc_d_q;
  logic [SC_W-1:0]        seq_cnt_q, seq_cnt_d;
  logic [TO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [CH_W-1:0]        ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]        done_ch_q, done_ch_d;
  logic                   done_q, done_d;
  logic                   tmo_err_q, tmo_err_d;
  logic                   start_q;
  logic                   busy_q;

  assign eoc_s = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous eoc pin and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      eoc_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], eoc};
      eoc_d_q <= eoc_s;
    end
  end

  // Where to go once a conversion ends, whether it completed or timed out.
  always_comb begin
    resume_s = S_IDLE;
    if (enable && continuous) begin
      if (GAP > 0) begin
        resume_s = S_GAP;
      end else begin
        resume_s = S_START;
      end
    end else begin
      resume_s = S_IDLE;
    end
  end

  // Next-state, channel rotation and result/abort pulses.
  always_comb begin
    state_d   = state_q;
    ch_sel_d  = ch_sel_q;
    done_ch_d = done_ch_q;
    done_d    = 1'b0;
    tmo_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (continuous || trigger)) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (seq_cnt_q == SW_LAST) begin
          state_d = S_WAIT_HI;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT_HI: begin
        if (eoc_s) begin
          state_d = S_WAIT_LO;
        end else if (tmo_cnt_q >= TO_LIM) begin
          tmo_err_d = 1'b1;
          state_d   = resume_s;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (eoc_d_q && !eoc_s) begin
          done_d    = 1'b1;
          done_ch_d = ch_sel_q;
          if (ch_sel_q == CH_LAST) begin
            ch_sel_d = {CH_W{1'b0}};
          end else begin
            ch_sel_d = ch_sel_q + CH_W'(1'b1);
          end
          state_d = resume_s;
        end else if (tmo_cnt_q >= TO_LIM) begin
          tmo_err_d = 1'b1;
          state_d   = resume_s;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (seq_cnt_q == GAP_LAST) begin
          state_d = S_START;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters restart on every state entry; the timeout counter saturates.
  always_comb begin
    seq_cnt_d = {SC_W{1'b0}};
    tmo_cnt_d = {TO_W{1'b0}};
    if (state_d != state_q) begin
      seq_cnt_d = {SC_W{1'b0}};
      tmo_cnt_d = {TO_W{1'b0}};
    end else begin
      if ((state_q == S_START) || (state_q == S_GAP)) begin
        seq_cnt_d = seq_cnt_q + SC_W'(1'b1);
      end else begin
        seq_cnt_d = {SC_W{1'b0}};
      end
      if ((state_q == S_WAIT_HI) || (state_q == S_WAIT_LO)) begin
        if (tmo_cnt_q != {TO_W{1'b1}}) begin
          tmo_cnt_d = tmo_cnt_q + TO_W'(1'b1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end else begin
        tmo_cnt_d = {TO_W{1'b0}};
      end
    end
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      seq_cnt_q <= {SC_W{1'b0}};
      tmo_cnt_q <= {TO_W{1'b0}};
      ch_sel_q  <= {CH_W{1'b0}};
      done_ch_q <= {CH_W{1'b0}};
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      ch_sel_q  <= ch_sel_d;
      done_ch_q <= done_ch_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
      start_q   <= (state_d == S_START);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign start       = start_q;
  assign ch_sel      = ch_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_ch     = done_ch_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer. The bench acts as the ADC: after
// each START it raises/drops eoc at randomised offsets and predicts, from the
// timing rules alone, when done or timeout_err must pulse and which channel
// must be reported.
module tb_adc_conv_sequencer;

  localparam int SW   = 2;
  localparam int NCH  = 4;
  localparam int GAPC = 3;
  localparam int TO   = 15;
  localparam int NS   = 3;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            continuous;
  logic            trigger;
  logic            eoc;
  logic            start;
  logic [CH_W-1:0] ch_sel;
  logic            busy;
  logic            done;
  logic [CH_W-1:0] done_ch;
  logic            timeout_err;

  adc_conv_sequencer #(
    .START_WIDTH(SW), .NUM_CH(NCH), .GAP(GAPC), .TIMEOUT(TO), .SYNC_STAGES(NS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .continuous(continuous),
    .trigger(trigger), .eoc(eoc), .start(start), .ch_sel(ch_sel), .busy(busy),
    .done(done), .done_ch(done_ch), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad = 0;
  // Reference model state.
  int exp_ch = 0;
  int last_done_ch = 0;
  int last_evt_cyc = 0;
  bit gap_chk = 1'b0;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_start"}, start, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_tmo"}, timeout_err, 0);
    check_val({tag, "_ch_sel"}, ch_sel, 0);
    check_val({tag, "_done_ch"}, done_ch, 0);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_val("idle", {busy, start}, 0);
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("start_seen", seen, 1);
  endtask

  // One conversion: eoc rises a cycles after WAIT_HI entry (start falling),
  // stays high h cycles. Event cycle is derived from sync depth and timeout.
  task automatic run_conv(input int a, input int h, input bit trig_mid, input bit drop_en);
    bit seen;
    int w;
    int evt_n;
    bit is_tmo;
    wait_start(seen);
    if (!seen) return;
    if (gap_chk) check_val("gap", cyc - last_evt_cyc, GAPC);
    check_val("ch_sel_at_start", ch_sel, exp_ch);
    check_val("busy_at_start", busy, 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!start) break;
      w++;
    end
    check_val("start_width", w, SW);
    if (a + NS > TO) begin
      evt_n = TO + 1;
      is_tmo = 1'b1;
    end else if (h - 1 > TO) begin
      evt_n = a + NS + 1 + TO + 1;
      is_tmo = 1'b1;
    end else begin
      evt_n = a + h + NS + 1;
      is_tmo = 1'b0;
    end
    for (int n = 0; n <= evt_n + 1; n++) begin
      if (n > 0) @(negedge clk);
      if (n == evt_n) begin
        if (is_tmo) begin
          check_val("timeout_pulse", {done, timeout_err}, 1);
          check_val("done_ch_held", done_ch, last_done_ch);
        end else begin
          check_val("done_pulse", {done, timeout_err}, 2);
          check_val("done_ch", done_ch, exp_ch);
          last_done_ch = exp_ch;
          exp_ch = (exp_ch + 1) % NCH;
        end
        check_val("ch_sel_after", ch_sel, exp_ch);
        check_val("busy_after", busy, (enable && continuous) ? 1 : 0);
        last_evt_cyc = cyc;
        eoc = 1'b0;
      end else begin
        check_val("no_pulse", {done, timeout_err}, 0);
        if (n < evt_n) begin
          check_val("busy_during", busy, 1);
          check_val("start_during", start, 0);
          check_val("ch_sel_stable", ch_sel, exp_ch);
        end
      end
      if (n < evt_n) begin
        if (n == a) eoc = 1'b1;
        if (n == a + h) eoc = 1'b0;
        if (trig_mid && n <= 1) trigger = (n == 0);
        if (drop_en && n == a + NS + 2) enable = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    exp_ch = 0;
    last_done_ch = 0;
    gap_chk = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    enable = 1'b0;
    continuous = 1'b0;
    trigger = 1'b0;
    eoc = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Trigger while disabled is dropped.
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    idle_check(8);

    // Single shot on channel 0.
    enable = 1'b1;
    trigger = 1'b1;
    run_conv(3, 10, 1'b0, 1'b0);
    idle_check(5);

    // Trigger pulsed while busy is not queued.
    trigger = 1'b1;
    run_conv(2, 6, 1'b1, 1'b0);
    idle_check(10);

    // Random single shots.
    for (int k = 0; k < 4; k++) begin
      trigger = 1'b1;
      run_conv(int'($urandom_range(6, 0)), int'($urandom_range(10, 1)), 1'b0, 1'b0);
      idle_check(2);
    end

    // Timeouts in single-shot: eoc never rises, then eoc never falls.
    trigger = 1'b1;
    run_conv(100, 5, 1'b0, 1'b0);
    idle_check(4);
    trigger = 1'b1;
    run_conv(1, 20, 1'b0, 1'b0);
    idle_check(6);

    // Continuous with wrap; enable dropped in WAIT_LO of the last one.
    continuous = 1'b1;
    gap_chk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) run_conv(int'($urandom_range(6, 0)), 5, 1'b0, 1'b1);
      else run_conv(int'($urandom_range(6, 0)), int'($urandom_range(8, 1)), 1'b0, 1'b0);
      gap_chk = 1'b1;
    end
    idle_check(6);

    // Continuous timeout retries the same channel after the gap.
    enable = 1'b1;
    gap_chk = 1'b0;
    run_conv(100, 5, 1'b0, 1'b0);
    gap_chk = 1'b1;
    run_conv(2, 4, 1'b0, 1'b1);
    idle_check(4);
    continuous = 1'b0;
    gap_chk = 1'b0;

    // Async reset during START.
    enable = 1'b1;
    trigger = 1'b1;
    wait_start(seen);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid_start");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    trigger = 1'b1;
    run_conv(1, 4, 1'b0, 1'b0);
    idle_check(3);

    // Async reset during WAIT_LO.
    trigger = 1'b1;
    wait_start(seen);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!start) break;
    end
    eoc = 1'b1;
    repeat (7) @(negedge clk);
    check_val("in_wait_lo_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid_wait_lo");
    eoc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    trigger = 1'b1;
    run_conv(2, 3, 1'b0, 1'b0);
    idle_check(3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
